// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared constants and FSM encoding for pwm_capture
package pwm_capture_pkg;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_HIGH   = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int DUTY_W           = 7;
   localparam int STAT_VALID_BIT   = 8;
   localparam int STAT_OVERRUN_BIT = 9;
   localparam int STAT_BUSY_BIT    = 10;
   localparam int CTRL_ENABLE_BIT  = 0;

   localparam logic [DUTY_W-1:0] DUTY_FULL = 7'd100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } cap_state_t;

endpackage

// File: rtl/pwm_capture_div.sv
// rtl/pwm_capture_div.sv - serial restoring divider, one quotient bit per cycle
module pwm_capture_div
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W+6:0]  num,
   input  logic [CNT_W-1:0]  den,
   output logic [DUTY_W-1:0] quot,
   output logic              busy,
   output logic              done
);

   localparam int NUM_W  = CNT_W + 7;
   localparam int ITER_W = $clog2(NUM_W + 1);

   logic [CNT_W-1:0]  r_rem;
   logic [CNT_W-1:0]  r_den;
   logic [NUM_W-1:0]  r_num;
   logic [ITER_W-1:0] r_iter;
   logic              r_busy;

   logic [CNT_W-1:0]  w_src_rem;
   logic [CNT_W-1:0]  w_src_den;
   logic [NUM_W-1:0]  w_src_num;
   logic [CNT_W:0]    w_shift;
   logic              w_ge;
   logic [CNT_W-1:0]  w_rem_step;
   logic [NUM_W-1:0]  w_num_step;

   // One restoring step; on start it works on the fresh operands so the first bit costs no extra cycle
   always_comb begin
      w_src_rem  = start ? '0  : r_rem;
      w_src_num  = start ? num : r_num;
      w_src_den  = start ? den : r_den;
      w_shift    = {w_src_rem, w_src_num[NUM_W-1]};
      w_ge       = (w_shift >= {1'b0, w_src_den});
      // remainder stays below den, so the low CNT_W bits of the difference are exact
      w_rem_step = w_ge ? (w_shift[CNT_W-1:0] - w_src_den) : w_shift[CNT_W-1:0];
      w_num_step = {w_src_num[NUM_W-2:0], w_ge};
   end

   // Iteration state: NUM_W steps total, then a single done cycle with busy still high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_den  <= '0;
         r_num  <= '0;
         r_iter <= '0;
         r_busy <= 1'b0;
      end else if (abort) begin
         r_iter <= '0;
         r_busy <= 1'b0;
      end else if (start) begin
         r_rem  <= w_rem_step;
         r_num  <= w_num_step;
         r_den  <= den;
         r_iter <= ITER_W'(NUM_W - 1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_iter != '0) begin
            r_rem  <= w_rem_step;
            r_num  <= w_num_step;
            r_iter <= r_iter - ITER_W'(1);
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_busy && (r_iter == '0);
   assign quot = r_num[DUTY_W-1:0];

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture (period, high time, duty %); PWM_CAPTURE_TIMEOUT_EN adds stuck-pin timeout
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   input  logic [1:0]  A,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD
);

   localparam int               NUM_W   = CNT_W + 7;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              r_sync1;
   logic              r_sync2;
   logic              r_dly;
   cap_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_high_lat;
   logic [CNT_W-1:0]  r_op_high;
   logic [CNT_W-1:0]  r_op_period;
   logic [CNT_W-1:0]  r_period;
   logic [CNT_W-1:0]  r_high;
   logic [DUTY_W-1:0] r_duty;
   logic              r_valid;
   logic              r_overrun;
   logic              r_enable;

   logic              w_rise;
   logic              w_fall;
   cap_state_t        w_state_next;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_start;
   logic              w_latch_high;
   logic              w_overrun_set;
   logic              w_timeout;
   logic              w_stat_wr;
   logic              w_ctrl_wr;
   logic              w_abort;
   logic [NUM_W-1:0]  w_num;
   logic [DUTY_W-1:0] w_quot;
   logic              w_div_busy;
   logic              w_div_done;
   logic              w_unused;

   assign w_rise    = r_sync2 & ~r_dly;
   assign w_fall    = ~r_sync2 & r_dly;
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
   assign w_stat_wr = WE && (A == ADDR_STATUS);
   assign w_ctrl_wr = WE && (A == ADDR_CTRL);
   // kill the divide in the same cycle enable is written low so busy drops right after
   assign w_abort   = w_ctrl_wr ? ~WD[CTRL_ENABLE_BIT] : ~r_enable;
   assign w_num     = NUM_W'(r_high_lat) * NUM_W'(DUTY_FULL);
   assign w_unused  = ^{WD[31:10], WD[7:1]};

   // Synchronize the asynchronous pin, plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_dly   <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
      end
   end

   // Capture FSM state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Capture FSM next state, counter update and measurement strobes
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_start       = 1'b0;
      w_latch_high  = 1'b0;
      w_overrun_set = 1'b0;
      w_timeout     = 1'b0;
      if (!r_enable) begin
         w_state_next = ST_IDLE;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_ARM;
            end
            ST_ARM: begin
               if (w_rise) begin
                  w_cnt_next   = CNT_ONE;
                  w_state_next = ST_HIGH;
               end
            end
            ST_HIGH: begin
               w_cnt_next = w_cnt_inc;
               if (w_fall) begin
                  w_latch_high = 1'b1;
                  w_state_next = ST_LOW;
               end
`ifdef PWM_CAPTURE_TIMEOUT_EN
               else if (r_cnt == CNT_MAX) begin
                  w_timeout    = 1'b1;
                  w_state_next = ST_ARM;
               end
`endif
            end
            ST_LOW: begin
               w_cnt_next = w_cnt_inc;
               if (w_rise) begin
                  w_cnt_next   = CNT_ONE;
                  w_state_next = ST_HIGH;
                  // a period finishing while the divider still works is dropped, not queued
                  if (w_div_busy) begin
                     w_overrun_set = 1'b1;
                  end else begin
                     w_start = 1'b1;
                  end
               end
`ifdef PWM_CAPTURE_TIMEOUT_EN
               else if (r_cnt == CNT_MAX) begin
                  w_timeout    = 1'b1;
                  w_state_next = ST_ARM;
               end
`endif
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // High-time latch and the operand copy that travels with each divide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_high_lat  <= '0;
         r_op_high   <= '0;
         r_op_period <= '0;
      end else begin
         if (w_latch_high) begin
            r_high_lat <= r_cnt;
         end
         if (w_start) begin
            r_op_high   <= r_high_lat;
            r_op_period <= r_cnt;
         end
      end
   end

   pwm_capture_div #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_start),
      .abort (w_abort),
      .num   (w_num),
      .den   (r_cnt),
      .quot  (w_quot),
      .busy  (w_div_busy),
      .done  (w_div_done)
   );

   // Result registers and valid flag; a new result wins over a same-cycle W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty   <= '0;
         r_period <= '0;
         r_high   <= '0;
         r_valid  <= 1'b0;
      end else if (w_div_done) begin
         r_duty   <= w_quot;
         r_period <= r_op_period;
         r_high   <= r_op_high;
         r_valid  <= 1'b1;
      end else if (w_timeout) begin
         r_duty   <= r_sync2 ? DUTY_FULL : '0;
         r_period <= '0;
         r_high   <= '0;
         r_valid  <= 1'b1;
      end else if (w_stat_wr && WD[STAT_VALID_BIT]) begin
         r_valid  <= 1'b0;
      end
   end

   // Sticky overrun flag and the enable control bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
         r_enable  <= 1'b0;
      end else begin
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (w_stat_wr && WD[STAT_OVERRUN_BIT]) begin
            r_overrun <= 1'b0;
         end
         if (w_ctrl_wr) begin
            r_enable <= WD[CTRL_ENABLE_BIT];
         end
      end
   end

   // Register read mux
   always_comb begin
      RD = '0;
      case (A)
         ADDR_STATUS: begin
            RD[DUTY_W-1:0]      = r_duty;
            RD[STAT_VALID_BIT]   = r_valid;
            RD[STAT_OVERRUN_BIT] = r_overrun;
            RD[STAT_BUSY_BIT]    = w_div_busy;
         end
         ADDR_PERIOD: RD[CNT_W-1:0] = r_period;
         ADDR_HIGH:   RD[CNT_W-1:0] = r_high;
         ADDR_CTRL:   RD[CTRL_ENABLE_BIT] = r_enable;
         default:     RD = '0;
      endcase
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture at CNT_W=8
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   localparam int CW = 8;

   logic        clk;
   logic        rst_n;
   logic        pwm_in;
   logic [1:0]  A;
   logic        WE;
   logic [31:0] WD;
   logic [31:0] RD;

   int   n_checks = 0;
   int   n_errors = 0;

   int   pw_hi    = 5;
   int   pw_lo    = 7;
   int   pw_gen   = 0;
   logic pw_run   = 1'b1;
   logic pw_level = 1'b0;

   typedef struct {
      int period;
      int high;
      int duty;
      int overrun;
   } exp_t;

   exp_t sb_q[$];

   pwm_capture #(.CNT_W(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .A      (A),
      .WE     (WE),
      .WD     (WD),
      .RD     (RD)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // PWM pin generator: pw_hi cycles high then pw_lo low, restarted when pw_gen changes
   initial begin
      int ph;
      int gen_seen;
      ph = 0;
      gen_seen = 0;
      pwm_in = 1'b0;
      forever begin
         @(negedge clk);
         if (gen_seen != pw_gen) begin
            gen_seen = pw_gen;
            ph = 0;
         end
         if (pw_run) begin
            pwm_in = (ph < pw_hi);
            ph = (ph + 1 >= pw_hi + pw_lo) ? 0 : ph + 1;
         end else begin
            pwm_in = pw_level;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      A  = a;
      WD = d;
      WE = 1'b1;
      @(negedge clk);
      WE = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      A = a;
      #1;
      d = RD;
   endtask

   task automatic push_meas(input int p, input int h, input int ov);
      exp_t e;
      e.period  = p;
      e.high    = h;
      e.duty    = (h * 100) / p;
      e.overrun = ov;
      sb_q.push_back(e);
   endtask

   task automatic setup(input int hi, input int lo);
      write_reg(ADDR_CTRL, 32'd0);
      pw_hi  = hi;
      pw_lo  = lo;
      pw_run = 1'b1;
      pw_gen++;
      write_reg(ADDR_STATUS, 32'h300);
      repeat (4) @(negedge clk);
      write_reg(ADDR_CTRL, 32'd1);
   endtask

   task automatic check_result(input string tag);
      exp_t        e;
      logic        seen;
      logic [31:0] d;
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         read_reg(ADDR_STATUS, d);
         seen = d[STAT_VALID_BIT];
      end
      check({tag, "_valid"}, {31'b0, seen}, 32'd1);
      e = sb_q.pop_front();
      read_reg(ADDR_PERIOD, d);
      check({tag, "_period"}, d, e.period);
      read_reg(ADDR_HIGH, d);
      check({tag, "_high"}, d, e.high);
      read_reg(ADDR_STATUS, d);
      check({tag, "_duty"}, {25'b0, d[6:0]}, e.duty);
      check({tag, "_overrun"}, {31'b0, d[STAT_OVERRUN_BIT]}, e.overrun);
   endtask

   initial begin
      logic [31:0] d;
      logic        seen;
      rst_n = 1'b0;
      A     = 2'd0;
      WE    = 1'b0;
      WD    = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset in the middle of a running measurement, pin toggling throughout
      write_reg(ADDR_CTRL, 32'd1);
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         read_reg(a[1:0], d);
         check($sformatf("rst_reg%0d", a), d, 32'd0);
      end
      check("rst_state", {30'b0, dut.r_state}, {30'b0, ST_IDLE});
      rst_n = 1'b1;

      // 25 % duty
      setup(25, 75);
      push_meas(100, 25, 0);
      check_result("p25");

      // floor rounding with periods shorter than the divider latency
      setup(1, 2);
      push_meas(3, 1, 1);
      check_result("f33");
      setup(2, 1);
      push_meas(3, 2, 1);
      check_result("f66");

      // W1C of valid and overrun leaves duty alone
      write_reg(ADDR_CTRL, 32'd0);
      write_reg(ADDR_STATUS, 32'h300);
      read_reg(ADDR_STATUS, d);
      check("w1c_valid", {31'b0, d[STAT_VALID_BIT]}, 32'd0);
      check("w1c_overrun", {31'b0, d[STAT_OVERRUN_BIT]}, 32'd0);
      check("w1c_duty", {25'b0, d[6:0]}, 32'd66);

      // disable while the divider is busy
      setup(10, 30);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         read_reg(ADDR_STATUS, d);
         seen = d[STAT_BUSY_BIT];
      end
      check("dis_busy_seen", {31'b0, seen}, 32'd1);
      write_reg(ADDR_CTRL, 32'd0);
      A = ADDR_STATUS;
      #1;
      d = RD;
      check("dis_busy_clear", {31'b0, d[STAT_BUSY_BIT]}, 32'd0);
      repeat (60) @(negedge clk);
      read_reg(ADDR_STATUS, d);
      check("dis_no_valid", {31'b0, d[STAT_VALID_BIT]}, 32'd0);
      push_meas(40, 10, 0);
      write_reg(ADDR_CTRL, 32'd1);
      check_result("reen");

      // pin stuck high after one rising edge
      write_reg(ADDR_CTRL, 32'd0);
      pw_run   = 1'b0;
      pw_level = 1'b0;
      write_reg(ADDR_STATUS, 32'h300);
      repeat (4) @(negedge clk);
      write_reg(ADDR_CTRL, 32'd1);
      repeat (4) @(negedge clk);
      pw_level = 1'b1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      begin
         exp_t e;
         e.period  = 0;
         e.high    = 0;
         e.duty    = 100;
         e.overrun = 0;
         sb_q.push_back(e);
      end
      check_result("tmo");
`else
      repeat (600) @(negedge clk);
      read_reg(ADDR_STATUS, d);
      check("sat_no_valid", {31'b0, d[STAT_VALID_BIT]}, 32'd0);
      check("sat_cnt", {24'b0, dut.r_cnt}, 32'd255);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
